// File: rtl/frontend_issue_buffer_if.sv
// rtl/frontend_issue_buffer_if.sv - intake, issue and control signals of the issue buffer
interface frontend_issue_buffer_if #(
  parameter int WIDTH     = 128,
  parameter int IN_PORTS  = 2,
  parameter int OUT_PORTS = 2,
  parameter int DEPTH     = 4
);
  localparam int NW = $clog2(IN_PORTS + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic                                 flush_i;
  logic                                 hold_i;
  logic [IN_PORTS-1:0]                  in_valid_i;
  logic [IN_PORTS-1:0][WIDTH-1:0]       in_data_i;
  logic [NW-1:0]                        in_num_o;
  logic [OUT_PORTS-1:0]                 out_valid_o;
  logic [OUT_PORTS-1:0][WIDTH-1:0]      out_data_o;
  logic [OUT_PORTS-1:0]                 issue_i;
  logic [CW-1:0]                        count_o;

  modport master (
    output flush_i, hold_i, in_valid_i, in_data_i, issue_i,
    input  in_num_o, out_valid_o, out_data_o, count_o
  );

  modport slave (
    input  flush_i, hold_i, in_valid_i, in_data_i, issue_i,
    output in_num_o, out_valid_o, out_data_o, count_o
  );
endinterface

// File: rtl/frontend_issue_buffer.sv
// rtl/frontend_issue_buffer.sv - in-order compacting issue buffer; option macro ISSUE_BUF_FREE_ON_ISSUE_EN
module frontend_issue_buffer #(
  parameter int WIDTH     = 128,
  parameter int IN_PORTS  = 2,
  parameter int OUT_PORTS = 2,
  parameter int DEPTH     = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  frontend_issue_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(IN_PORTS + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] slot_q;
  logic [DEPTH-1:0][WIDTH-1:0] slot_d;
  logic [CW-1:0]               occ_q;
  logic [CW-1:0]               occ_d;
  logic [CW-1:0]               iss;
  logic [CW-1:0]               base;
  logic [CW-1:0]               free;
  logic [NW-1:0]               avail;
  logic [NW-1:0]               take;
  logic [OUT_PORTS-1:0]        out_valid;

  // Presentation: the oldest OUT_PORTS slots, valid below the occupancy count
  always_comb begin
    for (int k = 0; k < OUT_PORTS; k++) begin
      out_valid[k]       = (CW'(k) < occ_q);
      bus.out_data_o[k]  = slot_q[k];
    end
  end

  assign bus.out_valid_o = out_valid;
  assign bus.count_o     = occ_q;

  // Issued count: leading ones of issue mask restricted to valid slots
  always_comb begin
    logic run;
    iss = '0;
    run = 1'b1;
    for (int k = 0; k < OUT_PORTS; k++) begin
      if (run && bus.issue_i[k] && out_valid[k]) iss = iss + CW'(1);
      else                                       run = 1'b0;
    end
  end

  // Offered count: leading ones of the upstream valid mask
  always_comb begin
    logic run;
    avail = '0;
    run   = 1'b1;
    for (int i = 0; i < IN_PORTS; i++) begin
      if (run && bus.in_valid_i[i]) avail = avail + NW'(1);
      else                          run   = 1'b0;
    end
  end

  // Intake: bounded by free slots; refilling issued slots adds an issue->intake path
  always_comb begin
`ifdef ISSUE_BUF_FREE_ON_ISSUE_EN
    free = DEPTH_C - occ_q + iss;
`else
    free = DEPTH_C - occ_q;
`endif
    if (CW'(avail) < free) take = avail;
    else                   take = free[NW-1:0];
    if (!rst_n || bus.flush_i || bus.hold_i) take = '0;
  end

  assign bus.in_num_o = take;

  // Next state: shift survivors down by iss, append accepted packets behind them
  always_comb begin
    base   = occ_q - iss;
    occ_d  = base + CW'(take);
    slot_d = slot_q;
    for (int j = 0; j < DEPTH; j++) begin
      if (j < int'(base)) begin
        for (int s = 0; s <= OUT_PORTS; s++) begin
          if (s == int'(iss) && j + s < DEPTH) slot_d[j] = slot_q[j + s];
        end
      end else begin
        for (int i = 0; i < IN_PORTS; i++) begin
          if (j == int'(base) + i && i < int'(take)) slot_d[j] = bus.in_data_i[i];
        end
      end
    end
  end

  // Occupancy register: reset and flush both empty the buffer
  always_ff @(posedge clk) begin
    if (!rst_n)           occ_q <= '0;
    else if (bus.flush_i) occ_q <= '0;
    else                  occ_q <= occ_d;
  end

  // Data slots carry no reset; contents beyond occupancy are don't-care
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end
endmodule
